// File: rtl/alu_operand_datapath_if.sv
// alu_operand_datapath_if: operand/control inputs and result outputs of the execute-stage datapath
interface alu_operand_datapath_if #(parameter int WIDTH = 32);
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] old_pc;
  logic [WIDTH-1:0] rd1;
  logic [WIDTH-1:0] rd2;
  logic [24:0] imm_value;
  logic [2:0] imm_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_control;
  logic [WIDTH-1:0] imm_ext;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic [WIDTH-1:0] alu_result;
  logic zero;
  logic [WIDTH-1:0] alu_out;
  modport master (
    output pc, old_pc, rd1, rd2, imm_value, imm_src, alu_src_a, alu_src_b, alu_control,
    input imm_ext, src_a, src_b, alu_result, zero, alu_out
  );
  modport slave (
    input pc, old_pc, rd1, rd2, imm_value, imm_src, alu_src_a, alu_src_b, alu_control,
    output imm_ext, src_a, src_b, alu_result, zero, alu_out
  );
endinterface

// File: rtl/alu_operand_datapath.sv
// alu_operand_datapath: immediate extender, srcA/srcB muxes, ALU and registered ALUOut
module alu_operand_datapath #(parameter int WIDTH = 32) (
  input logic clk,
  input logic reset,
  alu_operand_datapath_if.slave bus
);
  logic [24:0] i;
  logic [WIDTH-1:0] imm, a, b, res, alu_out_d, alu_out_q;
  assign i = bus.imm_value;
  // i holds instr[31:7], so instr[n] is i[n-7]
  always_comb begin
    imm = bus.imm_src == 3'b000 ? WIDTH'($signed(i[24:13])) :
          bus.imm_src == 3'b001 ? WIDTH'($signed({i[24:18], i[4:0]})) :
          bus.imm_src == 3'b010 ? WIDTH'($signed({i[24], i[0], i[23:18], i[4:1], 1'b0})) :
          bus.imm_src == 3'b011 ? WIDTH'($signed({i[24], i[12:5], i[13], i[23:14], 1'b0})) :
          bus.imm_src == 3'b100 ? WIDTH'($signed({i[24:5], 12'b0})) : '0;
  end
  always_comb begin
    a = bus.alu_src_a == 2'b00 ? bus.pc :
        bus.alu_src_a == 2'b01 ? bus.old_pc :
        bus.alu_src_a == 2'b10 ? bus.rd1 : '0;
    b = bus.alu_src_b == 2'b00 ? bus.rd2 :
        bus.alu_src_b == 2'b01 ? imm :
        bus.alu_src_b == 2'b10 ? WIDTH'(4) : '0;
  end
  always_comb begin
    res = bus.alu_control == 3'b000 ? a + b :
          bus.alu_control == 3'b001 ? a - b :
          bus.alu_control == 3'b010 ? a & b :
          bus.alu_control == 3'b011 ? a | b :
          bus.alu_control == 3'b100 ? a ^ b :
          bus.alu_control == 3'b101 ? {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)} :
          bus.alu_control == 3'b110 ? {{(WIDTH-1){1'b0}}, a < b} :
          a << b[4:0];
  end
  assign alu_out_d = res;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) alu_out_q <= '0;
    else alu_out_q <= alu_out_d;
  end
  assign bus.imm_ext = imm;
  assign bus.src_a = a;
  assign bus.src_b = b;
  assign bus.alu_result = res;
  assign bus.zero = res == '0;
  assign bus.alu_out = alu_out_q;
endmodule

// File: tb/tb_alu_operand_datapath.sv
// tb_alu_operand_datapath: directed vectors feed a scoreboard queue; a negedge monitor pops and compares
module tb_alu_operand_datapath;
  typedef struct {
    string name;
    logic [24:0] imm_value;
    logic [2:0] imm_src;
    logic [1:0] sa;
    logic [1:0] sb;
    logic [2:0] ctl;
    logic [31:0] pc, old_pc, rd1, rd2;
    logic [31:0] e_imm, e_a, e_b, e_res;
  } vec_t;
  typedef struct {
    string name;
    logic [31:0] e_imm, e_a, e_b, e_res, e_out;
  } exp_t;
  logic clk = 0;
  logic reset = 0;
  int passed = 0;
  int total = 0;
  vec_t vecs[15];
  exp_t sb_q[$];
  logic [31:0] model_out = 0;
  logic [31:0] prev_res = 0;
  alu_operand_datapath_if #(.WIDTH(32)) bus ();
  alu_operand_datapath #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  function automatic void check(string n, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", n, act, exp);
  endfunction
  always @(negedge clk) begin
    while (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      check({e.name, ".imm_ext"}, bus.imm_ext, e.e_imm);
      check({e.name, ".src_a"}, bus.src_a, e.e_a);
      check({e.name, ".src_b"}, bus.src_b, e.e_b);
      check({e.name, ".alu_result"}, bus.alu_result, e.e_res);
      check({e.name, ".zero"}, {31'b0, bus.zero}, {31'b0, e.e_res == 32'b0});
      check({e.name, ".alu_out"}, bus.alu_out, e.e_out);
    end
  end
  task automatic step(int k, logic rst_new);
    exp_t e;
    @(posedge clk);
    if (reset) model_out = prev_res;
    #1;
    bus.imm_value = vecs[k].imm_value;
    bus.imm_src = vecs[k].imm_src;
    bus.alu_src_a = vecs[k].sa;
    bus.alu_src_b = vecs[k].sb;
    bus.alu_control = vecs[k].ctl;
    bus.pc = vecs[k].pc;
    bus.old_pc = vecs[k].old_pc;
    bus.rd1 = vecs[k].rd1;
    bus.rd2 = vecs[k].rd2;
    reset = rst_new;
    if (!rst_new) model_out = 0;
    e = '{vecs[k].name, vecs[k].e_imm, vecs[k].e_a, vecs[k].e_b, vecs[k].e_res, model_out};
    sb_q.push_back(e);
    prev_res = vecs[k].e_res;
  endtask
  initial begin
    bus.imm_value = 0; bus.imm_src = 0; bus.alu_src_a = 0; bus.alu_src_b = 0; bus.alu_control = 0;
    bus.pc = 0; bus.old_pc = 0; bus.rd1 = 0; bus.rd2 = 0;
    vecs[0]  = '{"s_imm", 25'd15, 3'b001, 2'b01, 2'b01, 3'b000, 0, 4, 0, 0, 32'd15, 32'd4, 32'd15, 32'd19};
    vecs[1]  = '{"i_imm", 25'h1FFE000, 3'b000, 2'b10, 2'b01, 3'b000, 0, 0, 1, 0, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0};
    vecs[2]  = '{"pc4", 25'd0, 3'b000, 2'b01, 2'b10, 3'b000, 0, 4, 0, 0, 32'd0, 32'd4, 32'd4, 32'd8};
    vecs[3]  = '{"and", 25'd0, 3'b000, 2'b01, 2'b10, 3'b010, 0, 4, 0, 0, 32'd0, 32'd4, 32'd4, 32'd4};
    vecs[4]  = '{"sub_eq", 25'd0, 3'b000, 2'b10, 2'b00, 3'b001, 0, 0, 30, 30, 32'd0, 32'd30, 32'd30, 32'd0};
    vecs[5]  = '{"slt", 25'd0, 3'b000, 2'b10, 2'b00, 3'b101, 0, 0, 32'hFFFFFFFF, 1, 32'd0, 32'hFFFFFFFF, 32'd1, 32'd1};
    vecs[6]  = '{"sltu", 25'd0, 3'b000, 2'b10, 2'b00, 3'b110, 0, 0, 32'hFFFFFFFF, 1, 32'd0, 32'hFFFFFFFF, 32'd1, 32'd0};
    vecs[7]  = '{"sll", 25'd0, 3'b000, 2'b10, 2'b00, 3'b111, 0, 0, 1, 33, 32'd0, 32'd1, 32'd33, 32'd2};
    vecs[8]  = '{"or", 25'd0, 3'b000, 2'b10, 2'b00, 3'b011, 0, 0, 32'hF0F00000, 32'h00000F0F, 32'd0, 32'hF0F00000, 32'h00000F0F, 32'hF0F00F0F};
    vecs[9]  = '{"xor", 25'd0, 3'b000, 2'b10, 2'b00, 3'b100, 0, 0, 32'hFFFF0000, 32'hFF00FF00, 32'd0, 32'hFFFF0000, 32'hFF00FF00, 32'h00FFFF00};
    vecs[10] = '{"b_imm", 25'h1FC0019, 3'b010, 2'b00, 2'b01, 3'b000, 32'h100, 0, 0, 0, 32'hFFFFFFF8, 32'h100, 32'hFFFFFFF8, 32'h000000F8};
    vecs[11] = '{"j_imm", 25'h0002000, 3'b011, 2'b00, 2'b01, 3'b000, 32'h1000, 0, 0, 0, 32'h00000800, 32'h1000, 32'h00000800, 32'h00001800};
    vecs[12] = '{"u_imm", 25'h02468A0, 3'b100, 2'b11, 2'b01, 3'b000, 32'h55, 0, 0, 0, 32'h12345000, 32'd0, 32'h12345000, 32'h12345000};
    vecs[13] = '{"bad_imm5", 25'h1FFFFFF, 3'b101, 2'b11, 2'b11, 3'b011, 7, 7, 7, 7, 32'd0, 32'd0, 32'd0, 32'd0};
    vecs[14] = '{"bad_imm7", 25'h1FFFFFF, 3'b111, 2'b11, 2'b01, 3'b000, 7, 7, 7, 7, 32'd0, 32'd0, 32'd0, 32'd0};
    step(0, 1'b0);
    step(0, 1'b1);
    for (int k = 1; k < 15; k++) step(k, 1'b1);
    step(2, 1'b1);
    step(2, 1'b1);
    step(2, 1'b0);
    step(0, 1'b0);
    step(4, 1'b0);
    step(5, 1'b1);
    step(6, 1'b1);
    step(7, 1'b1);
    @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      total++;
      $display("FAIL drain: got %0d pending expected 0", sb_q.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
